adis_read_seq: RTL
==================

ADIS_READ_SEQ -- requirements
Module: adis_read_seq

Interface
REQ-001 Parameter STALL_CYCLES, default 384: idle clocks between the end of one SPI frame and the next request (sensor stall time).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: maximum clocks to wait for spi_done after spi_req.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to run one read sequence.
REQ-006 spi_req  out  1  one-cycle pulse starting one 16-bit SPI frame.
REQ-007 spi_wr_en  out  1  write-enable to SPI master; always 0.
REQ-008 spi_data_tx  out  16  command word for the frame.
REQ-009 spi_data_rx  in  16  word shifted in during the last frame; valid when spi_done=1.
REQ-010 spi_done  in  1  one-cycle pulse marking frame completion.
REQ-011 busy  out  1  high from start acceptance until return to IDLE.
REQ-012 supply / xaccl / yaccl / temp  out  16 each  raw published sensor words.
REQ-013 valid  out  1  one-cycle pulse when a new sample set is published.
REQ-014 err  out  1  one-cycle pulse on timeout.

Function
REQ-015 States are IDLE, REQ, WAIT, STALL and FINISH.
REQ-016 Read command word SHALL be {1'b0, addr[6:0], 8'h00}.
REQ-017 The frame sequence SHALL be five frames with addr 0x02 (SUPPLY), 0x04 (XACCL), 0x06 (YACCL), 0x0A (TEMP), 0x02 (flush).
REQ-018 Sensor reads are pipelined: the response to frame 0 SHALL be discarded, and the responses to frames 1..4 SHALL be captured into the supply, xaccl, yaccl and temp shadow registers respectively.
REQ-019 IDLE: start=1 SHALL move to REQ with frame index 0 and busy=1 on the next cycle; start while busy SHALL be ignored.
REQ-020 REQ: the FSM SHALL drive spi_data_tx with the current command, assert spi_req for exactly one cycle, clear the timeout counter and go to WAIT.
REQ-021 spi_data_tx SHALL remain stable from the spi_req cycle until spi_done.
REQ-022 WAIT, spi_done=1: the FSM SHALL capture spi_data_rx per REQ-018 in that cycle.
REQ-023 WAIT, spi_done=1, index<4: the FSM SHALL increment the index and go to STALL.
REQ-024 WAIT, spi_done=1, index=4: the FSM SHALL go to FINISH.
REQ-025 WAIT: if TIMEOUT_CYCLES clocks elapse without spi_done, the FSM SHALL pulse err for one cycle and return to IDLE, leave published outputs unchanged, and not pulse valid.
REQ-026 STALL: the FSM SHALL count STALL_CYCLES clocks, then go to REQ; next spi_req SHALL occur exactly STALL_CYCLES+1 cycles after the spi_done cycle.
REQ-027 FINISH: the FSM SHALL copy all four shadows to the outputs simultaneously, pulse valid for one cycle, then go to IDLE with busy=0 in the following cycle.
REQ-028 Outputs SHALL change only in FINISH, so a partial sequence is never visible.
REQ-029 spi_done outside WAIT SHALL be ignored.
REQ-030 A start in the FINISH cycle SHALL be ignored; start is accepted only in IDLE.
REQ-031 Latency from start to valid, with an ideal SPI master taking F clocks per frame, SHALL be 5*(F+1) + 4*STALL_CYCLES + 2 cycles (±1 is not permitted).
REQ-032 Counters SHALL be sized by clog2 of their parameters and SHALL saturate, never wrap.

Reset
REQ-033 On rst, state SHALL be IDLE.
REQ-034 On rst, busy, spi_req, spi_wr_en, valid and err SHALL be 0.
REQ-035 On rst, spi_data_tx, shadows, outputs, index and counters SHALL be 0.
REQ-036 rst mid-sequence SHALL abort immediately with no valid pulse; the first start after release SHALL begin at frame 0.

Verification
REQ-037 Nominal: SPI model returns 0x8100+addr of the previous frame, F=16, STALL_CYCLES=4 -> commands 0x0200,0x0400,0x0600,0x0A00,0x0200 are sent; the frame 0 response is discarded; valid pulses once with supply=0x8102, xaccl=0x8104, yaccl=0x8106, temp=0x810A; latency equals REQ-031.
REQ-038 Timeout: suppress spi_done on frame 2, TIMEOUT_CYCLES=64 -> err pulses 64 cycles after the third spi_req, busy drops, outputs keep their previous values and valid never pulses.
REQ-039 Start spam: assert start every cycle during a sequence -> exactly one sequence runs and spi_req pulses exactly 5 times.
REQ-040 Reset mid-WAIT on frame 3 -> all outputs return to 0 asynchronously; after release, a new start produces a clean 5-frame sequence.
REQ-041 Stray spi_done pulses in IDLE and STALL -> no capture and no state change; stall spacing stays exactly STALL_CYCLES+1.
REQ-042 Back-to-back: a start in the cycle after busy falls -> it is accepted; the second valid shows updated values and the first set is held until then.

Source files
------------

// File: rtl/adis_read_seq.sv
// rtl/adis_read_seq.sv - ADIS accelerometer burst reader: five pipelined SPI frames, stall spacing, timeout.
// Frame N returns the word requested by frame N-1, so frame 0 is a discarded primer and frame 4 a flush.
module adis_read_seq #(
  parameter int STALL_CYCLES   = 384,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        spi_req,
  output logic        spi_wr_en,
  output logic [15:0] spi_data_tx,
  input  logic [15:0] spi_data_rx,
  input  logic        spi_done,
  output logic        busy,
  output logic [15:0] supply,
  output logic [15:0] xaccl,
  output logic [15:0] yaccl,
  output logic [15:0] temp,
  output logic        valid,
  output logic        err
);

  localparam int SW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] STALL_LAST = (STALL_CYCLES > 1) ? SW'(STALL_CYCLES - 1) : '0;
  // Outputs are registered, so err becomes visible one clock after the last WAIT cycle.
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 2) ? TW'(TIMEOUT_CYCLES - 2) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_STALL,
    S_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [15:0]     tx_q, tx_d;
  logic            req_q, req_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [15:0]     sh_supply_q, sh_supply_d;
  logic [15:0]     sh_xaccl_q, sh_xaccl_d;
  logic [15:0]     sh_yaccl_q, sh_yaccl_d;
  logic [15:0]     sh_temp_q, sh_temp_d;
  logic [15:0]     supply_q, supply_d;
  logic [15:0]     xaccl_q, xaccl_d;
  logic [15:0]     yaccl_q, yaccl_d;
  logic [15:0]     temp_q, temp_d;

  function automatic logic [15:0] cmd_word(input logic [2:0] idx);
    logic [6:0] addr;
    case (idx)
      3'd1:    addr = 7'h04;
      3'd2:    addr = 7'h06;
      3'd3:    addr = 7'h0A;
      default: addr = 7'h02;
    endcase
    return {1'b0, addr, 8'h00};
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stall_cnt_d = stall_cnt_q;
    to_cnt_d    = to_cnt_q;
    sh_supply_d = sh_supply_q;
    sh_xaccl_d  = sh_xaccl_q;
    sh_yaccl_d  = sh_yaccl_q;
    sh_temp_d   = sh_temp_q;
    supply_d    = supply_q;
    xaccl_d     = xaccl_q;
    yaccl_d     = yaccl_q;
    temp_d      = temp_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          idx_d   = 3'd0;
        end
      end
      S_REQ: begin
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (spi_done) begin
          case (idx_q)
            3'd1:    sh_supply_d = spi_data_rx;
            3'd2:    sh_xaccl_d  = spi_data_rx;
            3'd3:    sh_yaccl_d  = spi_data_rx;
            3'd4:    sh_temp_d   = spi_data_rx;
            default: ;
          endcase
          if (idx_q == 3'd4) begin
            state_d = S_FINISH;
          end else begin
            idx_d       = idx_q + 3'd1;
            stall_cnt_d = '0;
            state_d     = (STALL_CYCLES > 0) ? S_STALL : S_REQ;
          end
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_STALL: begin
        if (stall_cnt_q == STALL_LAST) begin
          state_d = S_REQ;
        end else begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end
      S_FINISH: begin
        supply_d = sh_supply_q;
        xaccl_d  = sh_xaccl_q;
        yaccl_d  = sh_yaccl_q;
        temp_d   = sh_temp_q;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_d  = (state_d == S_REQ);
    tx_d   = req_d ? cmd_word(idx_d) : tx_q;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      stall_cnt_q <= '0;
      to_cnt_q    <= '0;
      tx_q        <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      sh_supply_q <= '0;
      sh_xaccl_q  <= '0;
      sh_yaccl_q  <= '0;
      sh_temp_q   <= '0;
      supply_q    <= '0;
      xaccl_q     <= '0;
      yaccl_q     <= '0;
      temp_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stall_cnt_q <= stall_cnt_d;
      to_cnt_q    <= to_cnt_d;
      tx_q        <= tx_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      sh_supply_q <= sh_supply_d;
      sh_xaccl_q  <= sh_xaccl_d;
      sh_yaccl_q  <= sh_yaccl_d;
      sh_temp_q   <= sh_temp_d;
      supply_q    <= supply_d;
      xaccl_q     <= xaccl_d;
      yaccl_q     <= yaccl_d;
      temp_q      <= temp_d;
    end
  end

  assign spi_req     = req_q;
  assign spi_wr_en   = 1'b0;
  assign spi_data_tx = tx_q;
  assign busy        = busy_q;
  assign valid       = valid_q;
  assign err         = err_q;
  assign supply      = supply_q;
  assign xaccl       = xaccl_q;
  assign yaccl       = yaccl_q;
  assign temp        = temp_q;

endmodule
